// File: rtl/cla_nibble_serial_adder_if.sv
// rtl/cla_nibble_serial_adder_if.sv - operand/result handshake bundle for cla_nibble_serial_adder
// Optional gp/gg group outputs exist only when CLA_GROUP_PG_EN is defined.
interface cla_nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
`ifdef CLA_GROUP_PG_EN
   logic             gp;
   logic             gg;
`endif

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
`ifdef CLA_GROUP_PG_EN
      , input gp, gg
`endif
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
`ifdef CLA_GROUP_PG_EN
      , output gp, gg
`endif
   );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// rtl/cla_nibble_serial_adder.sv - nibble-serial adder reusing one 4-bit carry-lookahead slice
// Define CLA_GROUP_PG_EN to add full-word group propagate/generate outputs (gp/gg).
module cla_nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   cla_nibble_serial_adder_if.slave    bus
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d, ovf_q, ovf_d;
   logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
`ifdef CLA_GROUP_PG_EN
   logic               gp_q, gp_d, gg_q, gg_d;
   logic               nib_gp, nib_gg;
`endif

   logic [IDX_W+1:0]   off;
   logic [3:0]         p, g;
   logic               c0, c1, c2, c3, c4;

   always_comb begin
      off = {idx_q, 2'b00};
      p   = a_q[off +: 4] ^ b_q[off +: 4];
      g   = a_q[off +: 4] & b_q[off +: 4];
      c0  = carry_q;
      // Fully expanded lookahead: every carry is two gate levels from P/G/C0.
      c1  = g[0] | (c0 & p[0]);
      c2  = g[1] | (g[0] & p[1]) | (c0 & p[0] & p[1]);
      c3  = g[2] | (g[1] & p[2]) | (g[0] & p[1] & p[2]) | (c0 & p[0] & p[1] & p[2]);
      c4  = g[3] | (g[2] & p[3]) | (g[1] & p[2] & p[3]) | (g[0] & p[1] & p[2] & p[3])
          | (c0 & p[0] & p[1] & p[2] & p[3]);
`ifdef CLA_GROUP_PG_EN
      nib_gp = &p;
      nib_gg = g[3] | (g[2] & p[3]) | (g[1] & p[2] & p[3]) | (g[0] & p[1] & p[2] & p[3]);
`endif
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef CLA_GROUP_PG_EN
      gp_d        = gp_q;
      gg_d        = gg_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d        = bus.a;
               b_d        = bus.b;
               carry_d    = bus.cin;
               idx_d      = '0;
               in_ready_d = 1'b0;
               state_d    = RUN;
`ifdef CLA_GROUP_PG_EN
               gp_d       = 1'b1;
               gg_d       = 1'b0;
`endif
            end
         end
         RUN: begin
            sum_d[off +: 4] = p ^ {c3, c2, c1, c0};
            carry_d         = c4;
            idx_d           = idx_q + 1'b1;
`ifdef CLA_GROUP_PG_EN
            // Nibbles arrive LSB first, so the new nibble sits above the running group.
            gp_d            = gp_q & nib_gp;
            gg_d            = nib_gg | (nib_gp & gg_q);
`endif
            if (idx_q == IDX_W'(NIBBLES - 1)) begin
               cout_d      = c4;
               ovf_d       = c3 ^ c4;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef CLA_GROUP_PG_EN
         gp_q        <= 1'b0;
         gg_q        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef CLA_GROUP_PG_EN
         gp_q        <= gp_d;
         gg_q        <= gg_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
`ifdef CLA_GROUP_PG_EN
   assign bus.gp        = gp_q;
   assign bus.gg        = gg_q;
`endif
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb/tb_cla_nibble_serial_adder.sv - randomized self-checking bench for cla_nibble_serial_adder
// Expected results come from plain integer addition of the applied operands.
module tb_cla_nibble_serial_adder;
   localparam int WIDTH   = 16;
   localparam int NIBBLES = WIDTH / 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   cla_nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

   cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input int hold);
      logic [WIDTH:0]   full;
      logic [WIDTH:0]   gen;
      logic [WIDTH-1:0] exp_sum;
      logic             exp_cout, exp_ovf;
      int               k;

      full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      exp_sum  = full[WIDTH-1:0];
      exp_cout = full[WIDTH];
      exp_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (exp_sum[WIDTH-1] != a[WIDTH-1]);
      gen      = {1'b0, a} + {1'b0, b};

      @(negedge clk);
      check_eq("in_ready_idle", {31'b0, bus.in_ready}, 32'd1);
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a        = WIDTH'($urandom());
      bus.b        = WIDTH'($urandom());
      bus.cin      = 1'($urandom());

      k = 0;
      while (k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (bus.out_valid) break;
      end
      check_eq("latency", k, NIBBLES);
      check_eq("sum", {16'b0, bus.sum}, {16'b0, exp_sum});
      check_eq("cout", {31'b0, bus.cout}, {31'b0, exp_cout});
      check_eq("ovf", {31'b0, bus.ovf}, {31'b0, exp_ovf});
`ifdef CLA_GROUP_PG_EN
      check_eq("gp", {31'b0, bus.gp}, {31'b0, &(a ^ b)});
      check_eq("gg", {31'b0, bus.gg}, {31'b0, gen[WIDTH]});
`endif

      // Offer a new operand while DONE; it must be ignored.
      bus.in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("hold_valid", {31'b0, bus.out_valid}, 32'd1);
         check_eq("hold_sum", {16'b0, bus.sum}, {16'b0, exp_sum});
         check_eq("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      @(negedge clk);
      check_eq("release_valid", {31'b0, bus.out_valid}, 32'd0);
      check_eq("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check_eq("retain_sum", {16'b0, bus.sum}, {16'b0, exp_sum});
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      check_eq("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check_eq("rst_sum", {16'b0, bus.sum}, 32'd0);
      check_eq("rst_cout", {31'b0, bus.cout}, 32'd0);
      check_eq("rst_ovf", {31'b0, bus.ovf}, 32'd0);
      rst = 1'b0;

      run_op(16'h1234, 16'h4321, 1'b0, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1);
      run_op(16'h7FFF, 16'h0001, 1'b0, 0);
      run_op(16'hAAAA, 16'h5555, 1'b1, 0);
      run_op(16'h8000, 16'h8000, 1'b0, 3);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 2);

      // Reset two cycles into RUN discards the operation.
      @(negedge clk);
      bus.a        = 16'h1111;
      bus.b        = 16'h2222;
      bus.cin      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrun_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check_eq("midrun_sum", {16'b0, bus.sum}, 32'd0);
      check_eq("midrun_in_ready", {31'b0, bus.in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      check_eq("midrun_no_pulse", {31'b0, bus.out_valid}, 32'd0);
      rst = 1'b0;
      run_op(16'h0001, 16'h0001, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         run_op(WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom()),
                int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
